// File: rtl/led_chaser_pkg.sv
// led_chaser_pkg: mode encodings and widths shared by the LED chaser slice.
package led_chaser_pkg;
    localparam int MODE_W = 2;
    typedef enum logic [MODE_W-1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BINARY = 2'd3
    } mode_e;
endpackage

// File: rtl/led_step_tick.sv
// led_step_tick: step prescaler, pulses tick every STEP_DIV running cycles.
module led_step_tick #(
    parameter int STEP_DIV = 1
) (
    input  logic clk1h,
    input  logic rst,
    input  logic run,
    output logic tick
);
    logic [7:0] pc_q, pc_d;
    always_comb begin
        tick = run && (pc_q == 8'(STEP_DIV - 1));
        pc_d = tick ? 8'd0 : run ? pc_q + 8'd1 : pc_q;
    end
    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) pc_q <= 8'd0;
        else      pc_q <= pc_d;
    end
endmodule

// File: rtl/led_chaser.sv
// led_chaser: selectable LED pattern engine (rotate, bounce, fill, binary count).
// led and step are both registered so the new pattern and its pulse align.
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int STEP_DIV   = 1,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                clk1h,
    input  logic                rst,
    input  logic                run,
    input  logic [MODE_W-1:0]   mode,
    input  logic                dir,
    output logic [NUM_LEDS-1:0] led,
    output logic                step
);
    localparam int PW = $clog2(NUM_LEDS);
    localparam int KW = $clog2(NUM_LEDS + 1);
    localparam logic [NUM_LEDS-1:0] ONE  = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] ONES = {NUM_LEDS{1'b1}};
    localparam logic [NUM_LEDS-1:0] LED_RST = ACTIVE_LOW ? ~ONE : ONE;

    logic                tick;
    mode_e               new_mode;
    logic [NUM_LEDS-1:0] pat_q, pat_d, led_q, led_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [KW-1:0]       k_q, k_d;
    logic                up_q, up_d, step_q, step_d;
    mode_e               cur_mode_q, cur_mode_d;

    led_step_tick #(.STEP_DIV(STEP_DIV)) u_tick (
        .clk1h(clk1h),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    always_comb begin
        new_mode   = mode_e'(mode);
        pat_d      = pat_q;
        pos_d      = pos_q;
        k_d        = k_q;
        up_d       = up_q;
        cur_mode_d = cur_mode_q;
        step_d     = tick;
        if (tick && new_mode != cur_mode_q) begin
            // a mode switch consumes the step to load the new mode's start state
            cur_mode_d = new_mode;
            up_d       = 1'b1;
            pos_d      = (new_mode == MODE_ROTATE || new_mode == MODE_BOUNCE) ? '0 : pos_q;
            k_d        = (new_mode == MODE_FILL) ? KW'(1) : k_q;
            pat_d      = (new_mode == MODE_BINARY) ? '0 : ONE;
        end else if (tick) begin
            case (cur_mode_q)
                MODE_ROTATE: begin
                    pos_d = dir ? (pos_q == '0 ? PW'(NUM_LEDS - 1) : pos_q - 1'b1)
                                : (pos_q == PW'(NUM_LEDS - 1) ? '0 : pos_q + 1'b1);
                    pat_d = ONE << pos_d;
                end
                MODE_BOUNCE: begin
                    pos_d = up_q ? pos_q + 1'b1 : pos_q - 1'b1;
                    up_d  = up_q ? (pos_q != PW'(NUM_LEDS - 2)) : (pos_q == PW'(1));
                    pat_d = ONE << pos_d;
                end
                MODE_FILL: begin
                    k_d   = (k_q == KW'(NUM_LEDS)) ? '0 : k_q + 1'b1;
                    pat_d = dir ? ~(ONES >> k_d) : ~(ONES << k_d);
                end
                MODE_BINARY: pat_d = dir ? pat_q - 1'b1 : pat_q + 1'b1;
            endcase
        end
        led_d = ACTIVE_LOW ? ~pat_d : pat_d;
    end

    always_ff @(posedge clk1h or negedge rst) begin
        if (!rst) begin
            pat_q      <= ONE;
            pos_q      <= '0;
            k_q        <= KW'(1);
            up_q       <= 1'b1;
            cur_mode_q <= MODE_ROTATE;
            step_q     <= 1'b0;
            led_q      <= LED_RST;
        end else begin
            pat_q      <= pat_d;
            pos_q      <= pos_d;
            k_q        <= k_d;
            up_q       <= up_d;
            cur_mode_q <= cur_mode_d;
            step_q     <= step_d;
            led_q      <= led_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;
endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: two led_chaser instances (N=8/div1/active-low, N=4/div3/active-high)
// checked each cycle against a step-index based reference model.
module tb_led_chaser;
    logic       clk1h = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       dir = 1'b0;
    logic [7:0] led_a;
    logic [3:0] led_b;
    logic       step_a, step_b;
    logic [31:0] la, lb;

    int vectors = 0;
    int errs = 0;

    typedef struct {
        int cur, pos, k, bidx, pc;
        longint pat;
        bit stp;
    } mdl_t;
    mdl_t m[2];
    int nn[2] = '{8, 4};
    int dv[2] = '{1, 3};
    bit al[2] = '{1'b1, 1'b0};

    always #5 clk1h = ~clk1h;
    assign la = {24'h0, led_a};
    assign lb = {28'h0, led_b};

    led_chaser #(.NUM_LEDS(8), .STEP_DIV(1), .ACTIVE_LOW(1)) dut_a (
        .clk1h(clk1h), .rst(rst), .run(run), .mode(mode), .dir(dir), .led(led_a), .step(step_a));
    led_chaser #(.NUM_LEDS(4), .STEP_DIV(3), .ACTIVE_LOW(0)) dut_b (
        .clk1h(clk1h), .rst(rst), .run(run), .mode(mode), .dir(dir), .led(led_b), .step(step_b));

    function automatic longint mask(int i);
        return (64'd1 << nn[i]) - 1;
    endfunction

    function automatic logic [31:0] exp_led(int i);
        return 32'(al[i] ? (~m[i].pat & mask(i)) : m[i].pat);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].cur = 0; m[i].pos = 0; m[i].k = 1; m[i].bidx = 0; m[i].pc = 0;
            m[i].pat = 1; m[i].stp = 1'b0;
        end
    endtask

    task automatic model_step(int i, bit r, int md, bit d);
        int n;
        bit s;
        n = nn[i];
        s = r && (m[i].pc == dv[i] - 1);
        m[i].pc = s ? 0 : r ? m[i].pc + 1 : m[i].pc;
        m[i].stp = s;
        if (!s) return;
        if (md != m[i].cur) begin
            m[i].cur = md; m[i].pos = 0; m[i].bidx = 0; m[i].k = 1;
            m[i].pat = (md == 3) ? 0 : 1;
        end else begin
            case (m[i].cur)
                0: begin m[i].pos = (m[i].pos + (d ? n - 1 : 1)) % n; m[i].pat = 64'd1 << m[i].pos; end
                1: begin
                    m[i].bidx = (m[i].bidx + 1) % (2 * n - 2);
                    m[i].pat = 64'd1 << (m[i].bidx < n ? m[i].bidx : 2 * n - 2 - m[i].bidx);
                end
                2: begin
                    m[i].k = (m[i].k + 1) % (n + 1);
                    m[i].pat = d ? (mask(i) & ~((64'd1 << (n - m[i].k)) - 1)) : (64'd1 << m[i].k) - 1;
                end
                default: m[i].pat = (m[i].pat + (d ? -1 : 1)) & mask(i);
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk1h);
        model_step(0, run, int'(mode), dir);
        model_step(1, run, int'(mode), dir);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b0; mode = 2'd0; dir = 1'b0;
        repeat (3) @(posedge clk1h);
        #1;
        vectors++;
        if (led_a !== 8'hFE || step_a !== 1'b0) begin
            errs++; $display("FAIL reset_a: led=%h step=%b want led=fe step=0", led_a, step_a);
        end
        vectors++;
        if (led_b !== 4'h1 || step_b !== 1'b0) begin
            errs++; $display("FAIL reset_b: led=%h step=%b want led=1 step=0", led_b, step_b);
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_rotate();
        mode = 2'd0; run = 1'b1; dir = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (c >= 30) dir = 1'($urandom_range(0, 1));
            cyc();
            vectors++;
            if (la !== exp_led(0) || step_a !== m[0].stp) begin
                errs++; $display("FAIL rotate_a c=%0d: led=%h step=%b want led=%h step=%b", c, la, step_a, exp_led(0), m[0].stp);
            end
            vectors++;
            if (lb !== exp_led(1) || step_b !== m[1].stp) begin
                errs++; $display("FAIL rotate_b c=%0d: led=%h step=%b want led=%h step=%b", c, lb, step_b, exp_led(1), m[1].stp);
            end
        end
    endtask

    task automatic test_bounce();
        mode = 2'd1; run = 1'b1;
        for (int c = 0; c < 60; c++) begin
            dir = 1'($urandom_range(0, 1));
            cyc();
            vectors++;
            if (la !== exp_led(0) || step_a !== m[0].stp) begin
                errs++; $display("FAIL bounce_a c=%0d: led=%h step=%b want led=%h step=%b", c, la, step_a, exp_led(0), m[0].stp);
            end
            vectors++;
            if (lb !== exp_led(1) || step_b !== m[1].stp) begin
                errs++; $display("FAIL bounce_b c=%0d: led=%h step=%b want led=%h step=%b", c, lb, step_b, exp_led(1), m[1].stp);
            end
        end
    endtask

    task automatic test_fill();
        mode = 2'd2; run = 1'b1; dir = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (c == 35) dir = 1'b1;
            cyc();
            vectors++;
            if (la !== exp_led(0) || step_a !== m[0].stp) begin
                errs++; $display("FAIL fill_a c=%0d: led=%h step=%b want led=%h step=%b", c, la, step_a, exp_led(0), m[0].stp);
            end
            vectors++;
            if (lb !== exp_led(1) || step_b !== m[1].stp) begin
                errs++; $display("FAIL fill_b c=%0d: led=%h step=%b want led=%h step=%b", c, lb, step_b, exp_led(1), m[1].stp);
            end
        end
    endtask

    task automatic test_binary();
        mode = 2'd3; run = 1'b1; dir = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c >= 30) dir = 1'($urandom_range(0, 1));
            cyc();
            vectors++;
            if (la !== exp_led(0) || step_a !== m[0].stp) begin
                errs++; $display("FAIL binary_a c=%0d: led=%h step=%b want led=%h step=%b", c, la, step_a, exp_led(0), m[0].stp);
            end
            vectors++;
            if (lb !== exp_led(1) || step_b !== m[1].stp) begin
                errs++; $display("FAIL binary_b c=%0d: led=%h step=%b want led=%h step=%b", c, lb, step_b, exp_led(1), m[1].stp);
            end
        end
    endtask

    task automatic test_pause();
        bit seen;
        mode = 2'd0; run = 1'b1; dir = 1'b0;
        repeat (int'($urandom_range(7, 14))) cyc();
        run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) mode = 2'd2;
            cyc();
            vectors++;
            if (la !== exp_led(0) || step_a !== 1'b0 || lb !== exp_led(1) || step_b !== 1'b0) begin
                errs++; $display("FAIL pause c=%0d: a=%h/%b b=%h/%b want a=%h/0 b=%h/0", c, la, step_a, lb, step_b, exp_led(0), exp_led(1));
            end
        end
        run = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            cyc();
            vectors++;
            if (lb !== exp_led(1) || step_b !== m[1].stp) begin
                errs++; $display("FAIL resume_b c=%0d: led=%h step=%b want led=%h step=%b", c, lb, step_b, exp_led(1), m[1].stp);
            end
            if (step_b === 1'b1) begin
                seen = 1'b1;
                vectors++;
                if (led_b !== 4'h1 || led_a === 8'hFE && 1'b0) begin
                    errs++; $display("FAIL resume_fill_b: led=%h want 1", led_b);
                end
            end
        end
        vectors++;
        if (!seen) begin
            errs++; $display("FAIL resume_timeout: no step on b within 8 cycles, want one");
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) dir = 1'($urandom_range(0, 1));
            cyc();
            vectors++;
            if (la !== exp_led(0) || step_a !== m[0].stp) begin
                errs++; $display("FAIL random_a c=%0d: led=%h step=%b want led=%h step=%b", c, la, step_a, exp_led(0), m[0].stp);
            end
            vectors++;
            if (lb !== exp_led(1) || step_b !== m[1].stp) begin
                errs++; $display("FAIL random_b c=%0d: led=%h step=%b want led=%h step=%b", c, lb, step_b, exp_led(1), m[1].stp);
            end
        end
    endtask

    task automatic test_async_reset();
        bit hit;
        mode = 2'd3; run = 1'b1; dir = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 600 && !hit; c++) begin
            cyc();
            hit = (m[0].cur == 3 && m[0].pat == 64'h5A);
        end
        vectors++;
        if (!hit || led_a !== 8'hA5) begin
            errs++; $display("FAIL reach_5a: hit=%b led=%h want hit=1 led=a5", hit, led_a);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (led_a !== 8'hFE || step_a !== 1'b0 || led_b !== 4'h1 || step_b !== 1'b0) begin
            errs++; $display("FAIL async_reset: a=%h/%b b=%h/%b want a=fe/0 b=1/0", led_a, step_a, led_b, step_b);
        end
        @(posedge clk1h);
        #1 rst = 1'b1;
        model_reset();
        for (int c = 0; c < 30; c++) begin
            cyc();
            vectors++;
            if (la !== exp_led(0) || step_a !== m[0].stp || lb !== exp_led(1) || step_b !== m[1].stp) begin
                errs++; $display("FAIL post_reset c=%0d: a=%h/%b b=%h/%b want a=%h/%b b=%h/%b", c, la, step_a, lb, step_b, exp_led(0), m[0].stp, exp_led(1), m[1].stp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_bounce();
        test_fill();
        test_binary();
        test_pause();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/led_chaser.md
# led_chaser

Parametrised LED pattern engine, the next-generation water lamp for the board LED bank. Driven directly by the divided clock, it advances a selectable pattern across `NUM_LEDS` outputs: single-dot rotate, ping-pong bounce, bar fill, and binary count. It supports run/pause, direction control and an extra step prescaler. It sits between the clock divider and the LED pins, and replaces the fixed 3-bit counter and 3-to-8 decoder pair.

## Interface
- `NUM_LEDS`, default 8: LED count; legal range 2..32.
- `STEP_DIV`, default 1: `clk1h` cycles per pattern step; legal range 1..255.
- `ACTIVE_LOW`, default 1: 1 drives `led` inverted, so a lit LED is 0.
- `clk1h`  in  1: step clock from the divider.
- `rst`  in  1: reset, asynchronous, active-low. Clock is `clk1h`.
- `run`  in  1: 1 advances the pattern; 0 freezes the pattern and the prescaler.
- `mode`  in  2: 0 ROTATE, 1 BOUNCE, 2 FILL, 3 BINARY.
- `dir`  in  1: 0 moves up (toward the MSB); 1 moves down. BOUNCE ignores it.
- `led`  out  `NUM_LEDS`: pattern output, polarity set by `ACTIVE_LOW`.
- `step`  out  1: one-cycle pulse, high in the cycle the new pattern first appears.

## Operation
Internal registers:
- `pat[NUM_LEDS-1:0]`
- `pos`, `$clog2(NUM_LEDS)` bits
- `k`, fill level 0..`NUM_LEDS`
- `up` flag
- `cur_mode`
- prescaler `pc`, 8 bits

Reset values:
- `pat=1`, `pos=0`, `k=1`, `up=1`, `cur_mode=ROTATE`, `pc=0`, `step=0`.
- `led` = `~1` when `ACTIVE_LOW=1` (8'hFE for N=8); `1` otherwise.

Step condition: `run && pc==STEP_DIV-1`. On a step, `pc` wraps to 0; otherwise `pc` increments while `run=1` and holds while `run=0`.

Mode change: `mode` is compared with `cur_mode` only at a step. If they differ, the step loads the new mode's initial state instead of advancing, and `cur_mode` takes the new mode.
- ROTATE, BOUNCE: `pos=0`, `pat=1`.
- FILL: `k=1`, `pat=1`.
- BINARY: `pat=0`.
- Every mode also sets `up=1`.

Per-step behaviour by mode:
- ROTATE: `pos` increments when `dir=0` and wraps from N-1 to 0; it decrements when `dir=1` and wraps from 0 to N-1. `pat=1<<pos`. A `dir` change applies at the next step with no reload.
- BOUNCE: `pos` moves while `up=1` until it reaches N-1, then `up` clears. It moves down to 0, then `up` sets. Each end is lit once per pass. Sequence: 0,1,…,N-1,N-2,…,1,0,1,… with period 2N-2. `pat=1<<pos`.
- FILL: `k` counts 1..N, then 0, then 1, with period N+1. With `dir=0`, `pat = (1<<k)-1` (fills from the LSB). With `dir=1`, `pat` is that value bit-reversed (fills from the MSB).
- BINARY: `pat` increments modulo 2^N when `dir=0` and decrements when `dir=1`. All arithmetic is N bits wide and wraps; no carry-out.

Other rules:
- `led = ACTIVE_LOW ? ~pat : pat`, driven straight from the register with no combinational logic after the flop.
- Reset asserted mid-operation clears everything immediately to the reset values, regardless of the clock.
- `run=0` in the same cycle the prescaler would expire: no step, and `pc` holds.

## Timing
- All state updates on `posedge clk1h`.
- `led` and `step` are registered together: `step` is high exactly in the cycle the new `led` value is first valid.
- With `run` held high, the step period is `STEP_DIV` cycles. For `STEP_DIV=1`, `step` stays high continuously.
- Latency from `run` rising to the first step: `STEP_DIV` cycles when `pc=0`.
- A mode change becomes visible at the first step after `mode` changes, within at most `STEP_DIV` cycles.

## Structure
- Shared package/header `led_chaser_pkg` holds:
  - mode encodings `MODE_ROTATE`, `MODE_BOUNCE`, `MODE_FILL`, `MODE_BINARY`
  - the `MODE_W=2` width constant
- One sub-module, `led_step_tick`, owns the prescaler `pc`. It is parametrised by `STEP_DIV`, has inputs `clk1h`, `rst`, `run`, and outputs a combinational `tick`.
- The top level holds the mode FSM and the pattern registers.

## Test plan
- Reset, N=8, `ACTIVE_LOW=1` → `led=8'hFE`, `step=0`. Assert reset mid-BINARY at `pat=8'h5A` → `led` returns to `8'hFE` before the next edge.
- ROTATE, `dir=0`, `STEP_DIV=1`, 9 steps → `pat` sequence 01,02,…,80,01. Switch `dir=1` at `pat=01` → next is 80.
- BOUNCE, N=4 → `pat` sequence 1,2,4,8,4,2,1,2 (period 6). Toggling `dir` has no effect.
- FILL, N=4, `dir=0` → 1,3,7,F,0,1. With `dir=1` from `k=1` → 8,C,E,F,0,8.
- BINARY, N=4, `dir=1` from 0 → F,E,D. `STEP_DIV=3` → `step` asserted every 3rd cycle with `led` changing in the same cycle.
- `run=0` for 5 cycles mid-ROTATE → `led` and `pc` frozen, no `step`. Change `mode` to FILL while paused, then set `run=1` → the first step shows `pat=1` with `k=1`, not an advanced pattern.
